// File: rtl/sram_write_driver_if.sv
// sram_write_driver_if
//   Write-request handshake between the SRAM controller and the column write
//   driver.
//   wr_valid / wr_ready : request handshake (transfer when both high at clk)
//   wr_data             : write word, bit i goes to column i
//   wr_mask             : 1 = column i written, 0 = column left untouched
//   wr_done             : one-cycle pulse when a write has fully completed
//   master modport = controller side, slave modport = write driver side.
interface sram_write_driver_if #(
    parameter int COLS = 16
);
    logic            wr_valid;
    logic            wr_ready;
    logic [COLS-1:0] wr_data;
    logic [COLS-1:0] wr_mask;
    logic            wr_done;

    modport master (output wr_valid, wr_data, wr_mask, input wr_ready, wr_done);
    modport slave  (input wr_valid, wr_data, wr_mask, output wr_ready, wr_done);
endinterface

// File: rtl/sram_write_driver.sv
// sram_write_driver
//   Write-path sequencer for one SRAM column group. Accepts a masked write word
//   and steps the array through precharge, word-line drive, differential
//   bitline drive and recovery, emitting real-valued BL/BLB levels.
//
//   Ports:
//     clk, rst_n : clock (rising edge), asynchronous active-low reset
//     wr         : request handshake (wr_valid/wr_ready/wr_data/wr_mask/wr_done)
//     pre_en     : bitline precharge enable
//     wl_en      : word-line enable for the selected row
//     drv_en     : per-column write driver enable
//     bl_wr      : BL drive level per column (VDD / VSS)
//     blb_wr     : BLB drive level per column (VDD / VSS)
//
//   Optional build macro WR_PIPE_EN: accept the next request during the last
//   RECOVER cycle so back-to-back writes skip the IDLE cycle.
//
//   Every output is decoded from registered state only; request inputs never
//   reach an output combinationally.
module sram_write_driver #(
    parameter int COLS       = 16,
    parameter int PRE_CYCLES = 2,
    parameter int DRV_CYCLES = 3,
    parameter int REC_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sram_write_driver_if.slave       wr,
    output logic                     pre_en,
    output logic                     wl_en,
    output logic [COLS-1:0]          drv_en,
    output real                      bl_wr  [0:COLS-1],
    output real                      blb_wr [0:COLS-1]
);
    localparam real VDD = 1.5;
    localparam real VSS = 0.0;

    localparam int MAXP = (PRE_CYCLES > DRV_CYCLES)
                        ? ((PRE_CYCLES > REC_CYCLES) ? PRE_CYCLES : REC_CYCLES)
                        : ((DRV_CYCLES > REC_CYCLES) ? DRV_CYCLES : REC_CYCLES);
    localparam int CW   = $clog2(MAXP + 1);

    localparam logic [CW-1:0] PRE_LAST = CW'(PRE_CYCLES - 1);
    localparam logic [CW-1:0] DRV_LAST = CW'(DRV_CYCLES - 1);
    localparam logic [CW-1:0] REC_LAST = CW'(REC_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRECHARGE = 2'd1,
        DRIVE     = 2'd2,
        RECOVER   = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [COLS-1:0] data_q, data_n;
    logic [COLS-1:0] mask_q, mask_n;
    logic            ready_int;
    logic            rec_last;
    logic            accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            data_q <= '0;
            mask_q <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            data_q <= data_n;
            mask_q <= mask_n;
        end
    end

    // Last RECOVER cycle: completion pulse, and (pipelined build) a second
    // accept window so the next write can follow without an IDLE cycle.
    assign rec_last = (state == RECOVER) && (cnt == REC_LAST);
    assign accept   = wr.wr_valid && ready_int;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        data_n    = data_q;
        mask_n    = mask_q;
        ready_int = 1'b0;
        pre_en    = 1'b0;
        wl_en     = 1'b0;
        drv_en    = '0;
        wr.wr_done = 1'b0;

        case (state)
            IDLE: begin
                ready_int = 1'b1;
                pre_en    = 1'b1;
                if (accept) begin
                    data_n  = wr.wr_data;
                    mask_n  = wr.wr_mask;
                    cnt_n   = '0;
                    state_n = PRECHARGE;
                end
            end
            PRECHARGE: begin
                pre_en = 1'b1;
                if (cnt == PRE_LAST) begin
                    cnt_n   = '0;
                    state_n = DRIVE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DRIVE: begin
                wl_en  = 1'b1;
                drv_en = mask_q;
                if (cnt == DRV_LAST) begin
                    cnt_n   = '0;
                    state_n = RECOVER;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RECOVER: begin
                pre_en = 1'b1;
`ifdef WR_PIPE_EN
                ready_int = rec_last;
`endif
                if (rec_last) begin
                    wr.wr_done = 1'b1;
                    cnt_n      = '0;
                    if (accept) begin
                        data_n  = wr.wr_data;
                        mask_n  = wr.wr_mask;
                        state_n = PRECHARGE;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign wr.wr_ready = ready_int;

    // Bitline levels: only masked columns in DRIVE are pulled apart; every
    // other column sits at the precharge level on both lines.
    always_comb begin
        for (int i = 0; i < COLS; i++) begin
            bl_wr[i]  = VDD;
            blb_wr[i] = VDD;
            if (state == DRIVE && mask_q[i]) begin
                bl_wr[i]  = data_q[i] ? VDD : VSS;
                blb_wr[i] = data_q[i] ? VSS : VDD;
            end
        end
    end
endmodule
